// File: rtl/shift_up_issue_ctrl_pkg.sv
// shift_up_pkg: shared types and constants for the SHIFTUP issue controller.
//   - Bit positions of the 135-bit chain word {vld, data, smc_id, bcast}.
//   - cru_word_t packed struct, per-requester state enum, ID legality helper.
package shift_up_pkg;

  localparam int CRU_W        = 135;
  localparam int DATA_W       = 128;
  localparam int ID_W         = 5;

  localparam int CRU_VLD_BIT  = 134;
  localparam int CRU_DATA_MSB = 133;
  localparam int CRU_DATA_LSB = 6;
  localparam int CRU_ID_MSB   = 5;
  localparam int CRU_ID_LSB   = 1;
  localparam int CRU_BC_BIT   = 0;

  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   smc_id;
    logic              bcast;
  } cru_word_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } req_state_e;

  // An ID is legal only if it addresses an SMC that exists on the chain.
  function automatic logic id_legal(input logic [ID_W-1:0] id, input int smc_cnt);
    return int'(id) < smc_cnt;
  endfunction

endpackage

// File: rtl/shift_up_issue_ctrl_if.sv
// shift_up_issue_ctrl_if: requester-side bundle of the SHIFTUP issue controller.
//   req_vld/req_data/req_smc_id/req_bcast : requester -> controller
//   req_rdy/done/err                      : controller -> requester
//   master modport = requester side, slave modport = controller side.
interface shift_up_issue_ctrl_if
  import shift_up_pkg::*;
#(
  parameter int NUM_REQ = 4
) ();

  logic [NUM_REQ-1:0]        req_vld;
  logic [NUM_REQ-1:0]        req_rdy;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ*ID_W-1:0]   req_smc_id;
  logic [NUM_REQ-1:0]        req_bcast;
  logic [NUM_REQ-1:0]        done;
  logic [NUM_REQ-1:0]        err;

  modport master (
    output req_vld, req_data, req_smc_id, req_bcast,
    input  req_rdy, done, err
  );

  modport slave (
    input  req_vld, req_data, req_smc_id, req_bcast,
    output req_rdy, done, err
  );

endinterface

// File: rtl/shift_up_issue_ctrl_rr_arbiter.sv
// rr_arbiter: N-way round-robin arbiter, one grant per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-index request (already qualified by the caller)
//   grant      : one-hot grant, combinational from req and the pointer
// The search starts at the pointer; after a grant the pointer moves to
// granted index + 1 (mod N). Every grant is an accept for this caller.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;

  always_comb begin
    int  idx;
    logic found;
    grant   = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        ptr_nxt    = PTR_W'((idx + 1) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else        ptr <= ptr_nxt;
  end

endmodule

// File: rtl/shift_up_issue_ctrl.sv
// shift_up_issue_ctrl: head-of-chain issue controller for the SHIFTUP chain.
//   clk, rst_n      : clock, asynchronous active-low reset
//   req_if (slave)  : per-requester vld/rdy/data/smc_id/bcast, done/err pulses
//   cru_shiftup_out : registered 135-bit word into SMC 0 {vld,data,id,bcast}
//   busy            : any requester waiting or chain word valid
// Optional build macro SHIFTUP_ISSUE_PERF_EN adds saturating counters
//   perf_issue_cnt (32), perf_stall_cnt (32), perf_err_cnt (16).
module shift_up_issue_ctrl
  import shift_up_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SMC_CNT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  shift_up_issue_ctrl_if.slave  req_if,
  output logic [CRU_W-1:0]      cru_shiftup_out,
  output logic                  busy
`ifdef SHIFTUP_ISSUE_PERF_EN
  ,
  output logic [31:0]           perf_issue_cnt,
  output logic [31:0]           perf_stall_cnt,
  output logic [15:0]           perf_err_cnt
`endif
);

  // Countdown holds smc_id+1, up to 32.
  localparam int CNT_W = 6;

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] legal;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] waiting;
  logic [NUM_REQ-1:0] done_q;
  logic [NUM_REQ-1:0] err_p1;
  req_state_e         state [NUM_REQ];
  logic [CNT_W-1:0]   cnt   [NUM_REQ];
  cru_word_t          issue_p0;
  cru_word_t          cru_p1;

  // ---- stage p0: eligibility, arbitration, word select ----
  always_comb begin
    elig    = '0;
    legal   = '0;
    waiting = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i]    = req_if.req_vld[i] && (state[i] == ST_IDLE);
      legal[i]   = id_legal(req_if.req_smc_id[i*ID_W +: ID_W], SMC_CNT);
      waiting[i] = (state[i] == ST_WAIT);
    end
  end

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (elig),
    .grant (grant)
  );

  assign req_if.req_rdy = grant;

  // Illegal IDs still take the grant but produce an empty word.
  always_comb begin
    issue_p0 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i] && legal[i]) begin
        issue_p0.vld    = 1'b1;
        issue_p0.data   = req_if.req_data[i*DATA_W +: DATA_W];
        issue_p0.smc_id = req_if.req_smc_id[i*ID_W +: ID_W];
        issue_p0.bcast  = req_if.req_bcast[i];
      end
    end
  end

  // ---- stage p1: registered chain word and reject pulse ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cru_p1 <= '0;
      err_p1 <= '0;
    end else begin
      cru_p1 <= issue_p0;
      err_p1 <= grant & ~legal;
    end
  end

  assign cru_shiftup_out[CRU_VLD_BIT]                = cru_p1.vld;
  assign cru_shiftup_out[CRU_DATA_MSB:CRU_DATA_LSB]  = cru_p1.data;
  assign cru_shiftup_out[CRU_ID_MSB:CRU_ID_LSB]      = cru_p1.smc_id;
  assign cru_shiftup_out[CRU_BC_BIT]                 = cru_p1.bcast;
  assign req_if.err                                  = err_p1;

  // Per-requester completion tracking. The count starts at id+1 in the
  // issue cycle; done is raised for the cycle in which it reads 0, and the
  // requester becomes eligible again the cycle after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        state[i]  <= ST_IDLE;
        cnt[i]    <= '0;
        done_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        case (state[i])
          ST_IDLE: begin
            done_q[i] <= 1'b0;
            if (grant[i] && legal[i]) begin
              state[i] <= ST_WAIT;
              cnt[i]   <= CNT_W'(req_if.req_smc_id[i*ID_W +: ID_W]) + CNT_W'(1);
            end
          end
          ST_WAIT: begin
            if (cnt[i] == '0) begin
              state[i]  <= ST_IDLE;
              done_q[i] <= 1'b0;
            end else begin
              cnt[i]    <= cnt[i] - CNT_W'(1);
              done_q[i] <= (cnt[i] == CNT_W'(1));
            end
          end
          default: begin
            state[i]  <= ST_IDLE;
            done_q[i] <= 1'b0;
          end
        endcase
      end
    end
  end

  assign req_if.done = done_q;
  assign busy        = cru_p1.vld | (|waiting);

`ifdef SHIFTUP_ISSUE_PERF_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
      perf_err_cnt   <= '0;
    end else begin
      if (|(grant & legal))  perf_issue_cnt <= sat_inc32(perf_issue_cnt);
      if (|(elig & ~grant))  perf_stall_cnt <= sat_inc32(perf_stall_cnt);
      if (|(grant & ~legal)) perf_err_cnt   <= sat_inc16(perf_err_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_shift_up_issue_ctrl.sv
// tb_shift_up_issue_ctrl: directed self-checking bench for shift_up_issue_ctrl
// (NUM_REQ=4, SMC_CNT=8). Inputs change 1 time unit after the rising edge,
// outputs are checked 4 units after the rising edge.
module tb_shift_up_issue_ctrl;
  import shift_up_pkg::*;

  localparam int NR = 4;
  localparam int SC = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [CRU_W-1:0] cru;
  logic             busy;
  int               compared   = 0;
  int               mismatched = 0;

  always #5 clk = ~clk;

  shift_up_issue_ctrl_if #(.NUM_REQ(NR)) bus ();

`ifdef SHIFTUP_ISSUE_PERF_EN
  logic [31:0] perf_issue_cnt;
  logic [31:0] perf_stall_cnt;
  logic [15:0] perf_err_cnt;
`endif

  shift_up_issue_ctrl #(.NUM_REQ(NR), .SMC_CNT(SC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_if          (bus),
    .cru_shiftup_out (cru),
    .busy            (busy)
`ifdef SHIFTUP_ISSUE_PERF_EN
    ,
    .perf_issue_cnt  (perf_issue_cnt),
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_err_cnt    (perf_err_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [CRU_W-1:0] obs, input logic [CRU_W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic set_req(input int k, input logic v, input logic [4:0] id,
                         input logic [127:0] d, input logic bc);
    bus.req_vld[k]             = v;
    bus.req_smc_id[k*5 +: 5]   = id;
    bus.req_data[k*128 +: 128] = d;
    bus.req_bcast[k]           = bc;
  endtask

  function automatic logic [CRU_W-1:0] word(input logic [127:0] d, input logic [4:0] id, input logic bc);
    return {1'b1, d, id, bc};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic [127:0] d2 [NR];
  logic [NR-1:0] seen;
  logic [NR-1:0] exp_rdy;
  logic [NR-1:0] exp_done;
  logic [CRU_W-1:0] exp_cru;

  initial begin
    rst_n          = 1'b0;
    bus.req_vld    = '0;
    bus.req_data   = '0;
    bus.req_smc_id = '0;
    bus.req_bcast  = '0;

    // Reset state
    tick();
    tick();
    settle();
    chk("rst_cru", cru, '0);
    chk("rst_flags", {busy, bus.err, bus.done, bus.req_rdy}, '0);
`ifdef SHIFTUP_ISSUE_PERF_EN
    chk("rst_perf", {perf_issue_cnt, perf_stall_cnt, perf_err_cnt}, '0);
`endif
    tick();
    rst_n = 1'b1;

    // Test 1: single request, id=3
    tick();
    set_req(0, 1'b1, 5'd3, {16{8'hA5}}, 1'b0);
    settle();
    chk("t1_rdy_a", bus.req_rdy, 4'b0001);
    tick();
    set_req(0, 1'b0, 5'd3, {16{8'hA5}}, 1'b0);
    settle();
    chk("t1_cru_t", cru, word({16{8'hA5}}, 5'd3, 1'b0));
    chk("t1_busy_t", busy, 1'b1);
    tick();
    settle();
    chk("t1_cru_t1", cru, '0);
    tick();
    tick();
    settle();
    chk("t1_done_t3", bus.done, 4'b0000);
    tick();
    settle();
    chk("t1_done_t4", bus.done, 4'b0001);
    chk("t1_busy_t4", busy, 1'b1);
    tick();
    settle();
    chk("t1_done_t5", bus.done, 4'b0000);
    chk("t1_busy_t5", busy, 1'b0);

    // Test 2: four requesters at once, id=0, pointer reset to 0
    do_reset();
    for (int k = 0; k < NR; k++) begin
      d2[k] = {4{32'hC0DE_0000 + 32'(k)}};
      set_req(k, 1'b1, 5'd0, d2[k], k[0]);
    end
    settle();
    chk("t2_rdy_c0", bus.req_rdy, 4'b0001);
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c - 1 < NR) bus.req_vld[c-1] = 1'b0;
      settle();
      exp_rdy  = (c < NR) ? NR'(1 << c) : '0;
      exp_cru  = (c <= NR) ? word(d2[c-1], 5'd0, 1'(c - 1)) : '0;
      exp_done = (c >= 2 && c <= 5) ? NR'(1 << (c - 2)) : '0;
      chk($sformatf("t2_rdy_c%0d", c), bus.req_rdy, exp_rdy);
      chk($sformatf("t2_cru_c%0d", c), cru, exp_cru);
      chk($sformatf("t2_done_c%0d", c), bus.done, exp_done);
    end
    chk("t2_busy_end", busy, 1'b0);
`ifdef SHIFTUP_ISSUE_PERF_EN
    chk("t2_perf_stall", perf_stall_cnt, 32'd3);
    chk("t2_perf_issue", perf_issue_cnt, 32'd4);
`endif

    // Test 3: back-to-back from requester 1, id=7, vld held high
    tick();
    set_req(1, 1'b1, 5'd7, {8{16'h1357}}, 1'b1);
    settle();
    chk("t3_rdy_a", bus.req_rdy, 4'b0010);
    tick();
    settle();
    chk("t3_cru_t", cru, word({8{16'h1357}}, 5'd7, 1'b1));
    seen = '0;
    for (int k = 0; k < 9; k++) begin
      seen = seen | bus.req_rdy;
      if (k == 8) chk("t3_done_t8", bus.done, 4'b0010);
      tick();
      settle();
    end
    chk("t3_rdy_blocked", seen, 4'b0000);
    chk("t3_rdy_t9", bus.req_rdy, 4'b0010);
    tick();
    bus.req_vld[1] = 1'b0;
    settle();
    chk("t3_cru_t10", cru, word({8{16'h1357}}, 5'd7, 1'b1));
    for (int k = 0; k < 8; k++) tick();
    settle();
    chk("t3_done2", bus.done, 4'b0010);
    tick();
    settle();
    chk("t3_busy_end", busy, 1'b0);

    // Test 4: illegal id on requester 2, then a legal one
    tick();
    set_req(2, 1'b1, 5'd9, {4{32'hDEAD_BEEF}}, 1'b0);
    settle();
    chk("t4_rdy_a", bus.req_rdy, 4'b0100);
    tick();
    set_req(2, 1'b1, 5'd4, {4{32'h0BAD_F00D}}, 1'b0);
    settle();
    chk("t4_err_a1", bus.err, 4'b0100);
    chk("t4_cru_a1", cru, '0);
    chk("t4_busy_a1", busy, 1'b0);
    chk("t4_rdy_a1", bus.req_rdy, 4'b0100);
    tick();
    bus.req_vld[2] = 1'b0;
    settle();
    chk("t4_err_a2", bus.err, 4'b0000);
    chk("t4_cru_a2", cru, word({4{32'h0BAD_F00D}}, 5'd4, 1'b0));
    chk("t4_done_a2", bus.done, 4'b0000);
    for (int k = 0; k < 5; k++) tick();
    settle();
    chk("t4_done_a7", bus.done, 4'b0100);
`ifdef SHIFTUP_ISSUE_PERF_EN
    chk("t4_perf_err", perf_err_cnt, 16'd1);
`endif
    tick();
    settle();
    chk("t4_busy_end", busy, 1'b0);

    // Test 5: done coincidence, req0 id=5 at t and req1 id=2 at t+3
    tick();
    set_req(0, 1'b1, 5'd5, {2{64'h0123_4567_89AB_CDEF}}, 1'b0);
    settle();
    chk("t5_rdy_a", bus.req_rdy, 4'b0001);
    tick();
    bus.req_vld[0] = 1'b0;
    settle();
    chk("t5_cru_t", cru, word({2{64'h0123_4567_89AB_CDEF}}, 5'd5, 1'b0));
    tick();
    tick();
    set_req(1, 1'b1, 5'd2, {2{64'hFEDC_BA98_7654_3210}}, 1'b1);
    settle();
    chk("t5_rdy_t2", bus.req_rdy, 4'b0010);
    tick();
    bus.req_vld[1] = 1'b0;
    settle();
    chk("t5_cru_t3", cru, word({2{64'hFEDC_BA98_7654_3210}}, 5'd2, 1'b1));
    tick();
    tick();
    settle();
    chk("t5_done_t5", bus.done, 4'b0000);
    tick();
    settle();
    chk("t5_done_t6", bus.done, 4'b0011);
    tick();
    settle();
    chk("t5_done_t7", bus.done, 4'b0000);
    chk("t5_busy_t7", busy, 1'b0);

    // Test 6: reset with two requests outstanding
    tick();
    set_req(0, 1'b1, 5'd7, {4{32'h5555_AAAA}}, 1'b0);
    set_req(1, 1'b1, 5'd7, {4{32'h3333_CCCC}}, 1'b0);
    settle();
    chk("t6_rdy_a", bus.req_rdy, 4'b0001);
    tick();
    bus.req_vld[0] = 1'b0;
    settle();
    chk("t6_rdy_a1", bus.req_rdy, 4'b0010);
    tick();
    bus.req_vld[1] = 1'b0;
    settle();
    chk("t6_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_cru", cru, '0);
    chk("t6_rst_flags", {busy, bus.err, bus.done}, '0);
    tick();
    rst_n = 1'b1;
    seen = '0;
    for (int k = 0; k < 12; k++) begin
      tick();
      settle();
      seen = seen | bus.done;
    end
    chk("t6_no_done", seen, 4'b0000);
    chk("t6_busy_post", busy, 1'b0);
    tick();
    for (int k = 0; k < NR; k++) set_req(k, 1'b1, 5'd0, '0, 1'b0);
    settle();
    chk("t6_ptr_zero", bus.req_rdy, 4'b0001);
    tick();
    bus.req_vld = '0;
    for (int k = 0; k < 4; k++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
